// File: rtl/wr_ptr_full_if.sv
// Write-side bus of the async FIFO pointer block: write request, synchronized read
// pointer in, and the pointer/address/status outputs back to the FIFO core.
interface wr_ptr_full_if #(
   parameter int ADDR_SIZE = 4
);
   logic                 WINC;
   logic [ADDR_SIZE:0]   WQ2_RPTR;
   logic [ADDR_SIZE:0]   WPTR;
   logic [ADDR_SIZE-1:0] WADDR;
   logic                 WFULL;
   logic                 WAFULL;
   logic [ADDR_SIZE:0]   WLEVEL;
   logic                 WOVF;

   modport master (
      output WINC,
      output WQ2_RPTR,
      input  WPTR,
      input  WADDR,
      input  WFULL,
      input  WAFULL,
      input  WLEVEL,
      input  WOVF
   );

   modport slave (
      input  WINC,
      input  WQ2_RPTR,
      output WPTR,
      output WADDR,
      output WFULL,
      output WAFULL,
      output WLEVEL,
      output WOVF
   );
endinterface

// File: rtl/wr_ptr_full.sv
// Write-domain pointer, full/almost-full/level generator for the async FIFO.
// Define WPTR_OVF_EN to build the sticky overflow flag; otherwise WOVF is tied low.
module wr_ptr_full #(
   parameter int ADDR_SIZE    = 4,
   parameter int AFULL_THRESH = 14
) (
   input  logic          WCLK,
   input  logic          WRST,
   wr_ptr_full_if.slave  bus
);

   localparam logic [ADDR_SIZE:0] AFULL_LVL = AFULL_THRESH[ADDR_SIZE:0];

   function automatic logic [ADDR_SIZE:0] bin2gray(input logic [ADDR_SIZE:0] b);
      return (b >> 1) ^ b;
   endfunction

   // Prefix XOR from the MSB down recovers the binary count from Gray code.
   function automatic logic [ADDR_SIZE:0] gray2bin(input logic [ADDR_SIZE:0] g);
      logic [ADDR_SIZE:0] b;
      b[ADDR_SIZE] = g[ADDR_SIZE];
      for (int i = ADDR_SIZE - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [ADDR_SIZE:0] wbin_r;
   logic [ADDR_SIZE:0] wptr_r;
   logic [ADDR_SIZE:0] wlevel_r;
   logic               wfull_r;
   logic               wafull_r;

   logic               accept_s;
   logic [ADDR_SIZE:0] wbinnext_s;
   logic [ADDR_SIZE:0] wgraynext_s;
   logic [ADDR_SIZE:0] rbin_s;
   logic [ADDR_SIZE:0] level_next_s;
   logic [ADDR_SIZE:0] full_cmp_s;
   logic               full_next_s;
   logic               afull_next_s;

   // Next-state pointer, full detection and fill level from the synchronized read pointer.
   always_comb begin
      accept_s     = bus.WINC & ~wfull_r;
      wbinnext_s   = wbin_r + {{ADDR_SIZE{1'b0}}, accept_s};
      wgraynext_s  = bin2gray(wbinnext_s);
      rbin_s       = gray2bin(bus.WQ2_RPTR);
      level_next_s = wbinnext_s - rbin_s;
      // Full when the write pointer is exactly one lap ahead: top two Gray bits differ.
      full_cmp_s   = {~bus.WQ2_RPTR[ADDR_SIZE:ADDR_SIZE-1], bus.WQ2_RPTR[ADDR_SIZE-2:0]};
      full_next_s  = (wgraynext_s == full_cmp_s);
      afull_next_s = (level_next_s >= AFULL_LVL);
   end

   // Pointer and status registers.
   always_ff @(posedge WCLK or posedge WRST) begin
      if (WRST) begin
         wbin_r   <= '0;
         wptr_r   <= '0;
         wlevel_r <= '0;
         wfull_r  <= 1'b0;
         wafull_r <= 1'b0;
      end else begin
         wbin_r   <= wbinnext_s;
         wptr_r   <= wgraynext_s;
         wlevel_r <= level_next_s;
         wfull_r  <= full_next_s;
         wafull_r <= afull_next_s;
      end
   end

`ifdef WPTR_OVF_EN
   logic wovf_r;

   // Sticky overflow: a write request seen while the registered full flag is set.
   always_ff @(posedge WCLK or posedge WRST) begin
      if (WRST) begin
         wovf_r <= 1'b0;
      end else if (bus.WINC && wfull_r) begin
         wovf_r <= 1'b1;
      end else begin
         wovf_r <= wovf_r;
      end
   end

   assign bus.WOVF = wovf_r;
`else
   assign bus.WOVF = 1'b0;
`endif

   assign bus.WPTR   = wptr_r;
   assign bus.WADDR  = wbin_r[ADDR_SIZE-1:0];
   assign bus.WFULL  = wfull_r;
   assign bus.WAFULL = wafull_r;
   assign bus.WLEVEL = wlevel_r;

endmodule
